execute_cc_unit: RTL and testbench

EXECUTE_CC_UNIT -- requirements
Module: execute_cc_unit

---
 rtl/y86_pkg.sv | 39 +++
 rtl/execute_cc_unit_if.sv | 45 ++++
 rtl/execute_cc_unit_cond_eval.sv | 32 +++
 rtl/execute_cc_unit.sv | 111 +++++++++++
 tb/tb_execute_cc_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 constants for the execute-stage condition-code unit.
//   - icode values used by the E stage (NOP, CMOV, OPQ, JXX)
//   - ALU op select codes
//   - condition ifun codes for jXX / cmovXX
//   - RNONE register id and the M pipeline register layout
package y86_pkg;

    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_CMOV = 4'h2;
    localparam logic [3:0] I_OPQ  = 4'h6;
    localparam logic [3:0] I_JXX  = 4'h7;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic        valid;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] val_e;
        logic [3:0]  dst_e;
    } m_reg_t;

    localparam m_reg_t M_BUBBLE = '{valid: 1'b0, icode: I_NOP, cnd: 1'b0,
                                    val_e: 64'd0, dst_e: RNONE};

endpackage

// File: rtl/execute_cc_unit_if.sv
// execute_cc_unit_if: groups the E-stage inputs, pipeline controls and the
// M-register / CC outputs of execute_cc_unit.
//   master : drives the E-stage instruction and pipeline controls
//   slave  : the execute unit itself
interface execute_cc_unit_if (
    input logic clk
);
    logic        e_valid;
    logic [3:0]  e_icode;
    logic [3:0]  e_ifun;
    logic [3:0]  e_dstE;
    logic [63:0] alu_result;
    logic        alu_overflow;
    logic        exc_hold;
    logic        m_stall;
    logic        m_bubble;
    logic [1:0]  alu_control;
    logic        e_cnd;
    logic        e_bad_ifun;
    logic        zf;
    logic        sf;
    logic        of;
    logic        m_valid;
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_valE;
    logic [3:0]  m_dstE;

    modport master (
        input  clk,
        output e_valid, e_icode, e_ifun, e_dstE, alu_result, alu_overflow,
               exc_hold, m_stall, m_bubble,
        input  alu_control, e_cnd, e_bad_ifun, zf, sf, of,
               m_valid, m_icode, m_cnd, m_valE, m_dstE
    );

    modport slave (
        input  clk,
        input  e_valid, e_icode, e_ifun, e_dstE, alu_result, alu_overflow,
               exc_hold, m_stall, m_bubble,
        output alu_control, e_cnd, e_bad_ifun, zf, sf, of,
               m_valid, m_icode, m_cnd, m_valE, m_dstE
    );

endinterface

// File: rtl/execute_cc_unit_cond_eval.sv
// cond_eval: Y86 condition table for jXX / cmovXX.
//   ifun       : condition code select
//   zf, sf, of : condition flags
//   cnd        : condition result (0 for undefined ifun 7-15)
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       cnd
);

    logic lt;

    always_comb begin
        lt  = sf ^ of;
        cnd = 1'b0;
        case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = lt | zf;
            C_L:      cnd = lt;
            C_E:      cnd = zf;
            C_NE:     cnd = ~zf;
            C_GE:     cnd = ~lt;
            C_G:      cnd = ~lt & ~zf;
            default:  cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_cc_unit.sv
// execute_cc_unit: Y86 execute-stage condition-code register, condition
// evaluation and E->M pipeline register.
//   clk, rst            : clock, synchronous active-high reset
//   e_* / alu_*         : E-stage instruction and combinational ALU results
//   exc_hold            : downstream exception pending, blocks CC updates
//   m_stall / m_bubble  : M register hold / bubble insert (bubble wins)
//   alu_control         : ALU op select for the E instruction
//   e_cnd, e_bad_ifun   : combinational condition and ifun-range flag
//   zf, sf, of          : registered condition codes
//   m_*                 : M pipeline register contents
module execute_cc_unit
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        e_valid,
    input  logic [3:0]  e_icode,
    input  logic [3:0]  e_ifun,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] alu_result,
    input  logic        alu_overflow,
    input  logic        exc_hold,
    input  logic        m_stall,
    input  logic        m_bubble,
    output logic [1:0]  alu_control,
    output logic        e_cnd,
    output logic        zf,
    output logic        sf,
    output logic        of,
    output logic        m_valid,
    output logic [3:0]  m_icode,
    output logic        m_cnd,
    output logic [63:0] m_valE,
    output logic [3:0]  m_dstE,
    output logic        e_bad_ifun
);

    logic   zf_q, sf_q, of_q;
    logic   zf_d, sf_d, of_d;
    m_reg_t m_q, m_d;
    logic   cnd_raw;
    logic   is_opq, is_cond, cc_upd;

    // Condition uses the flags as registered, before this cycle's update.
    cond_eval u_cond_eval (
        .ifun (e_ifun),
        .zf   (zf_q),
        .sf   (sf_q),
        .of   (of_q),
        .cnd  (cnd_raw)
    );

    always_comb begin
        is_opq      = (e_icode == I_OPQ);
        is_cond     = (e_icode == I_CMOV) || (e_icode == I_JXX);
        alu_control = is_opq ? e_ifun[1:0] : ALU_ADD;
        e_cnd       = is_cond ? cnd_raw : 1'b0;
        e_bad_ifun  = e_valid && ((is_opq && (e_ifun > 4'd3)) ||
                                  (is_cond && (e_ifun > 4'd6)));
        cc_upd      = e_valid && is_opq && !e_bad_ifun && !exc_hold;
    end

    always_comb begin
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (cc_upd) begin
            zf_d = (alu_result == 64'd0);
            sf_d = alu_result[63];
            of_d = alu_overflow;
        end
    end

    always_comb begin
        m_d = m_q;
        if (m_bubble) begin
            m_d = M_BUBBLE;
        end else if (!m_stall) begin
            m_d.valid = e_valid;
            m_d.icode = e_icode;
            m_d.cnd   = e_cnd;
            m_d.val_e = alu_result;
            // A cmov that fails its condition must not write back.
            m_d.dst_e = ((e_icode == I_CMOV) && !e_cnd) ? RNONE : e_dstE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
            m_q  <= M_BUBBLE;
        end else begin
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
            m_q  <= m_d;
        end
    end

    assign zf      = zf_q;
    assign sf      = sf_q;
    assign of      = of_q;
    assign m_valid = m_q.valid;
    assign m_icode = m_q.icode;
    assign m_cnd   = m_q.cnd;
    assign m_valE  = m_q.val_e;
    assign m_dstE  = m_q.dst_e;

endmodule

// File: tb/tb_execute_cc_unit.sv
// Scoreboard bench for execute_cc_unit: stimulus pushes expected values
// tagged with the cycle at which they must appear; a monitor on the falling
// edge pops and compares every entry that is due.
module tb_execute_cc_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    execute_cc_unit_if bus (.clk(clk));

    execute_cc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .e_valid      (bus.e_valid),
        .e_icode      (bus.e_icode),
        .e_ifun       (bus.e_ifun),
        .e_dstE       (bus.e_dstE),
        .alu_result   (bus.alu_result),
        .alu_overflow (bus.alu_overflow),
        .exc_hold     (bus.exc_hold),
        .m_stall      (bus.m_stall),
        .m_bubble     (bus.m_bubble),
        .alu_control  (bus.alu_control),
        .e_cnd        (bus.e_cnd),
        .zf           (bus.zf),
        .sf           (bus.sf),
        .of           (bus.of),
        .m_valid      (bus.m_valid),
        .m_icode      (bus.m_icode),
        .m_cnd        (bus.m_cnd),
        .m_valE       (bus.m_valE),
        .m_dstE       (bus.m_dstE),
        .e_bad_ifun   (bus.e_bad_ifun)
    );

    localparam int S_ALUC = 0, S_ECND = 1, S_BAD = 2, S_ZF = 3, S_SF = 4,
                   S_OF = 5, S_MVALID = 6, S_MICODE = 7, S_MCND = 8,
                   S_MVALE = 9, S_MDSTE = 10;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t keep[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] actual(input int sel);
        case (sel)
            S_ALUC:   return {62'd0, bus.alu_control};
            S_ECND:   return {63'd0, bus.e_cnd};
            S_BAD:    return {63'd0, bus.e_bad_ifun};
            S_ZF:     return {63'd0, bus.zf};
            S_SF:     return {63'd0, bus.sf};
            S_OF:     return {63'd0, bus.of};
            S_MVALID: return {63'd0, bus.m_valid};
            S_MICODE: return {60'd0, bus.m_icode};
            S_MCND:   return {63'd0, bus.m_cnd};
            S_MVALE:  return bus.m_valE;
            S_MDSTE:  return {60'd0, bus.m_dstE};
            default:  return 64'hDEAD;
        endcase
    endfunction

    // Monitor: compares every entry due this cycle, keeps the rest.
    always @(negedge clk) begin
        logic [63:0] act;
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].due == cyc) begin
                act = actual(sb[i].sel);
                total++;
                if (act !== sb[i].exp) begin
                    bad++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                             sb[i].name, act, sb[i].exp, cyc);
                end
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    // dly 0: combinational, checked this cycle; dly 1: after next edge.
    task automatic push(input string name, input int sel, input logic [63:0] exp,
                        input int dly);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        e.due  = cyc + dly;
        sb.push_back(e);
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] ic,
                         input logic [3:0] fn, input logic [3:0] dst,
                         input logic [63:0] alu, input logic ovf,
                         input logic exc, input logic stl, input logic bub);
        @(posedge clk);
        #1;
        rst              = r;
        bus.e_valid      = v;
        bus.e_icode      = ic;
        bus.e_ifun       = fn;
        bus.e_dstE       = dst;
        bus.alu_result   = alu;
        bus.alu_overflow = ovf;
        bus.exc_hold     = exc;
        bus.m_stall      = stl;
        bus.m_bubble     = bub;
    endtask

    task automatic push_cc(input string tag, input logic z, input logic s,
                           input logic o);
        push({tag, "_zf"}, S_ZF, {63'd0, z}, 1);
        push({tag, "_sf"}, S_SF, {63'd0, s}, 1);
        push({tag, "_of"}, S_OF, {63'd0, o}, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.e_valid = 0; bus.e_icode = 0; bus.e_ifun = 0; bus.e_dstE = 0;
        bus.alu_result = 0; bus.alu_overflow = 0; bus.exc_hold = 0;
        bus.m_stall = 0; bus.m_bubble = 0;

        // OPq in E while reset is held: update discarded, comb outputs live.
        drive(1, 1, 4'h6, 4'h3, 4'h2, 64'h5, 1, 0, 0, 0);
        push("rst_aluc", S_ALUC, 64'd3, 0);
        push("rst_bad", S_BAD, 64'd0, 0);
        push_cc("rst", 1, 0, 0);
        push("rst_mvalid", S_MVALID, 64'd0, 1);
        push("rst_micode", S_MICODE, 64'd1, 1);
        push("rst_mvale", S_MVALE, 64'd0, 1);
        push("rst_mdste", S_MDSTE, 64'hF, 1);

        // je after reset: zf=1 -> taken.
        drive(0, 1, 4'h7, 4'h3, 4'hF, 64'h0, 0, 0, 0, 0);
        push("je_cnd", S_ECND, 64'd1, 0);
        push("je_aluc", S_ALUC, 64'd0, 0);
        push_cc("je", 1, 0, 0);
        push("je_micode", S_MICODE, 64'd7, 1);
        push("je_mcnd", S_MCND, 64'd1, 1);

        // subq giving a negative result.
        drive(0, 1, 4'h6, 4'h1, 4'h2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 0, 0);
        push("sub_aluc", S_ALUC, 64'd1, 0);
        push("sub_cnd", S_ECND, 64'd0, 0);
        push_cc("sub", 0, 1, 0);
        push("sub_mvale", S_MVALE, 64'hFFFF_FFFF_FFFF_FFFD, 1);
        push("sub_mdste", S_MDSTE, 64'd2, 1);

        // jl sees sf=1, of=0.
        drive(0, 1, 4'h7, 4'h2, 4'hF, 64'h0, 0, 0, 0, 0);
        push("jl_cnd", S_ECND, 64'd1, 0);

        // Zero result under exc_hold: CC frozen.
        drive(0, 1, 4'h6, 4'h0, 4'h2, 64'h0, 1, 1, 0, 0);
        push_cc("exc", 0, 1, 0);

        // addq zero with overflow: zf=1, sf=0, of=1.
        drive(0, 1, 4'h6, 4'h0, 4'h2, 64'h0, 1, 0, 0, 0);
        push_cc("add0", 1, 0, 1);

        // cmovne with zf=1: not taken, dst suppressed.
        drive(0, 1, 4'h2, 4'h4, 4'h3, 64'h77, 0, 0, 0, 0);
        push("cmovne_cnd", S_ECND, 64'd0, 0);
        push("cmovne_mdste", S_MDSTE, 64'hF, 1);
        push("cmovne_micode", S_MICODE, 64'd2, 1);
        push("cmovne_mvale", S_MVALE, 64'h77, 1);

        // cmovle taken (zf=1): dst kept.
        drive(0, 1, 4'h2, 4'h1, 4'h3, 64'h78, 0, 0, 0, 0);
        push("cmovle_cnd", S_ECND, 64'd1, 0);
        push("cmovle_mdste", S_MDSTE, 64'd3, 1);
        push("cmovle_mcnd", S_MCND, 64'd1, 1);

        // Remaining conditions with zf=1, sf=0, of=1.
        drive(0, 1, 4'h7, 4'h5, 4'hF, 64'h0, 0, 0, 0, 0);
        push("jge_cnd", S_ECND, 64'd0, 0);
        drive(0, 1, 4'h7, 4'h6, 4'hF, 64'h0, 0, 0, 0, 0);
        push("jg_cnd", S_ECND, 64'd0, 0);
        drive(0, 1, 4'h7, 4'h0, 4'hF, 64'h0, 0, 0, 0, 0);
        push("jmp_cnd", S_ECND, 64'd1, 0);
        drive(0, 1, 4'h2, 4'h3, 4'h4, 64'h0, 0, 0, 0, 0);
        push("cmove_cnd", S_ECND, 64'd1, 0);
        drive(0, 1, 4'h7, 4'h7, 4'hF, 64'h0, 0, 0, 0, 0);
        push("jbad_flag", S_BAD, 64'd1, 0);
        push("jbad_cnd", S_ECND, 64'd0, 0);
        drive(0, 1, 4'h2, 4'h6, 4'h4, 64'h0, 0, 0, 0, 0);
        push("cmovg_bad", S_BAD, 64'd0, 0);
        drive(0, 1, 4'h4, 4'h3, 4'h4, 64'h0, 0, 0, 0, 0);
        push("other_cnd", S_ECND, 64'd0, 0);
        push("other_aluc", S_ALUC, 64'd0, 0);

        // Stall holds M; CC update still happens (andq -> all flags 0).
        drive(0, 1, 4'h7, 4'h0, 4'h5, 64'h10, 0, 0, 0, 0);
        push("ld_mvale", S_MVALE, 64'h10, 1);
        drive(0, 1, 4'h6, 4'h2, 4'h6, 64'h20, 0, 0, 1, 0);
        push("stall1_mvale", S_MVALE, 64'h10, 1);
        push("stall1_micode", S_MICODE, 64'd7, 1);
        push_cc("stall1", 0, 0, 0);
        drive(0, 1, 4'h7, 4'h0, 4'h6, 64'h20, 0, 0, 1, 0);
        push("stall2_mvale", S_MVALE, 64'h10, 1);
        push("stall2_mdste", S_MDSTE, 64'd5, 1);
        drive(0, 1, 4'h7, 4'h0, 4'h6, 64'h20, 0, 0, 1, 1);
        push("bub_mvalid", S_MVALID, 64'd0, 1);
        push("bub_micode", S_MICODE, 64'd1, 1);
        push("bub_mvale", S_MVALE, 64'd0, 1);
        push("bub_mdste", S_MDSTE, 64'hF, 1);

        // Bad OPq ifun: flagged, no CC change.
        drive(0, 1, 4'h6, 4'h5, 4'h2, 64'h0, 1, 0, 0, 0);
        push("opbad_flag", S_BAD, 64'd1, 0);
        push_cc("opbad", 0, 0, 0);

        // Bubble in E with icode=6: no CC change, M loads invalid.
        drive(0, 0, 4'h6, 4'h0, 4'h2, 64'h0, 1, 0, 0, 0);
        push("ebub_bad", S_BAD, 64'd0, 0);
        push_cc("ebub", 0, 0, 0);
        push("ebub_mvalid", S_MVALID, 64'd0, 1);

        drive(0, 0, 4'h1, 4'h0, 4'hF, 64'h0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
